pc_fetch_ctrl: RTL

Fetch-stage controller for the 16-bit pipelined CPU. It owns the architectural PC register and sequences instruction fetch over a variable-latency instruction-memory handshake. It resolves B/BR branches from the decode-stage condition code and the V/N/Z flags, and issues redirects and flushes. It also absorbs hazard stalls and HLT. It sits between instruction memory and the IF/ID pipeline register and replaces ad-hoc combinational next-PC logic.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/pc_fetch_ctrl_if.sv | 10 +
 rtl/branch_cond_eval.sv | 28 ++
 rtl/pc_fetch_ctrl.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: condition codes, flag bit positions, fetch FSM states,
// and the default reset PC.
package cpu_pkg;
   typedef enum logic [2:0] {
      CC_NE     = 3'b000,
      CC_EQ     = 3'b001,
      CC_GT     = 3'b010,
      CC_LT     = 3'b011,
      CC_GE     = 3'b100,
      CC_LE     = 3'b101,
      CC_OV     = 3'b110,
      CC_UNCOND = 3'b111
   } cc_e;

   localparam int FLAG_V = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_Z = 0;

   typedef enum logic [1:0] {
      ST_FETCH,
      ST_HOLD,
      ST_DRAIN,
      ST_HALTED
   } fetch_state_e;

   localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;
endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory fetch handshake: request/address out, ready/data back.
interface pc_fetch_ctrl_if;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ready;
   logic [15:0] imem_data;

   modport master (output imem_req, output imem_addr, input imem_ready, input imem_data);
   modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_data);
endinterface

// File: rtl/branch_cond_eval.sv
// Branch condition evaluator: ccc code against the {V,N,Z} flags.
module branch_cond_eval
   import cpu_pkg::*;
(
   input  logic [2:0] br_cond,
   input  logic [2:0] flags,
   output logic       cond_true
);
   logic v, n, z;
   assign v = flags[FLAG_V];
   assign n = flags[FLAG_N];
   assign z = flags[FLAG_Z];

   always_comb begin
      cond_true = 1'b0;
      case (cc_e'(br_cond))
         CC_NE:     cond_true = ~z;
         CC_EQ:     cond_true = z;
         CC_GT:     cond_true = ~z & ~n;
         CC_LT:     cond_true = n;
         CC_GE:     cond_true = z | (~z & ~n);
         CC_LE:     cond_true = z | n;
         CC_OV:     cond_true = v;
         CC_UNCOND: cond_true = 1'b1;
         default:   cond_true = 1'b0;
      endcase
   end
endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage controller: owns the PC, sequences the imem handshake, resolves
// branches from decode, and absorbs stall and HLT.
module pc_fetch_ctrl
   import cpu_pkg::*;
#(
   parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic                   clk,
   input  logic                   rst_n,
   pc_fetch_ctrl_if.master        imem,
   input  logic                   stall,
   input  logic                   br_valid,
   input  logic [2:0]             br_cond,
   input  logic                   br_is_reg,
   input  logic [8:0]             br_offset,
   input  logic [15:0]            br_reg,
   input  logic [15:0]            br_pc_plus2,
   input  logic [2:0]             flags,
   input  logic                   halt,
   output logic [15:0]            pc,
   output logic                   if_valid,
   output logic [15:0]            if_instr,
   output logic [15:0]            if_pc_plus2,
   output logic                   flush,
   output logic                   halted
);
   fetch_state_e state_q, state_d;
   logic [15:0]  pc_q, pc_d;
   logic [15:0]  drain_addr_q, drain_addr_d;
   logic         halt_pend_q, halt_pend_d;
   logic         req_en_q, req_en_d;
   logic         if_valid_q, if_valid_d;
   logic [15:0]  if_instr_q, if_instr_d;
   logic [15:0]  if_pc2_q, if_pc2_d;

   logic        cond_true, req, wait_rsp, resolving, taken, halt_go;
   logic [15:0] target, pc_inc;

   branch_cond_eval u_cond (.br_cond(br_cond), .flags(flags), .cond_true(cond_true));

   assign target = br_is_reg ? br_reg
                             : br_pc_plus2 + {{6{br_offset[8]}}, br_offset, 1'b0};
   assign pc_inc = pc_q + 16'd2;

   // req_en_q keeps the request low until the first edge after reset release.
   assign req       = req_en_q & (state_q == ST_FETCH || state_q == ST_DRAIN);
   assign wait_rsp  = req & ~imem.imem_ready;
   assign resolving = (state_q == ST_FETCH) || (state_q == ST_HOLD);
   assign taken     = resolving & br_valid & cond_true;
   assign halt_go   = resolving & halt & ~taken;

   assign imem.imem_req  = req;
   assign imem.imem_addr = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;
   assign flush          = taken;
   assign pc             = pc_q;
   assign if_valid       = if_valid_q;
   assign if_instr       = if_instr_q;
   assign if_pc_plus2    = if_pc2_q;
   assign halted         = (state_q == ST_HALTED);

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      drain_addr_d = drain_addr_q;
      halt_pend_d  = halt_pend_q;
      req_en_d     = 1'b1;
      if_valid_d   = if_valid_q;
      if_instr_d   = if_instr_q;
      if_pc2_d     = if_pc2_q;
      case (state_q)
         ST_FETCH: begin
            if (taken) begin
               pc_d       = target;
               if_valid_d = 1'b0;
               if (wait_rsp) begin
                  state_d      = ST_DRAIN;
                  drain_addr_d = pc_q;
                  halt_pend_d  = 1'b0;
               end
            end else if (halt_go) begin
               if_valid_d = 1'b0;
               if (wait_rsp) begin
                  state_d      = ST_DRAIN;
                  drain_addr_d = pc_q;
                  halt_pend_d  = 1'b1;
               end else begin
                  state_d = ST_HALTED;
               end
            end else if (req && imem.imem_ready) begin
               if_valid_d = 1'b1;
               if_instr_d = imem.imem_data;
               if_pc2_d   = pc_inc;
               if (stall) state_d = ST_HOLD;
               else       pc_d    = pc_inc;
            end else if (!stall) begin
               // decode consumed what it had; nothing new arrived
               if_valid_d = 1'b0;
            end
         end
         ST_HOLD: begin
            if (taken) begin
               pc_d       = target;
               if_valid_d = 1'b0;
               state_d    = ST_FETCH;
            end else if (halt_go) begin
               if_valid_d = 1'b0;
               state_d    = ST_HALTED;
            end else if (!stall) begin
               pc_d       = pc_inc;
               if_valid_d = 1'b0;
               state_d    = ST_FETCH;
            end
         end
         ST_DRAIN: begin
            if (imem.imem_ready) state_d = halt_pend_q ? ST_HALTED : ST_FETCH;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_FETCH;
         pc_q         <= RESET_PC;
         drain_addr_q <= '0;
         halt_pend_q  <= 1'b0;
         req_en_q     <= 1'b0;
         if_valid_q   <= 1'b0;
         if_instr_q   <= '0;
         if_pc2_q     <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         drain_addr_q <= drain_addr_d;
         halt_pend_q  <= halt_pend_d;
         req_en_q     <= req_en_d;
         if_valid_q   <= if_valid_d;
         if_instr_q   <= if_instr_d;
         if_pc2_q     <= if_pc2_d;
      end
   end
endmodule
